// File: rtl/cell_rmw_initiator.sv
// -----------------------------------------------------------------------------
// cell_rmw_initiator
//
// Purpose
//   Request initiator for the 4-bit cell RAM read/write port. It sits between
//   the sketch hash/update logic and the dual-port cell RAM. It accepts one
//   cell operation at a time over a valid/ready handshake:
//     READ     returns the cell value
//     WRITE    stores req_data and returns 0
//     ADD_SAT  adds req_data to the cell, clamps at all-ones, writes the
//              result back and returns it
//   It drives the RAM's multi-cycle request/complete protocol and produces
//   exactly one response pulse per accepted operation.
//
// Configuration
//   RMW_TIMEOUT_EN  When defined, a wait for ram_dout_valid gives up after
//                   TIMEOUT cycles. The op then answers with rsp_err=1 and
//                   rsp_data=0, and an ADD_SAT skips its write phase. When
//                   undefined, the initiator waits for the RAM indefinitely.
//
// Parameters
//   ADDR_W      cell address width
//   DATA_W      cell width
//   DEPTH       number of valid cells; addresses >= DEPTH are rejected
//   GAP_CYCLES  idle cycles after each ram_dout_valid before the next ram_en
//               (a value of 0 is treated as 1)
//   TIMEOUT     wait limit in cycles, used only with RMW_TIMEOUT_EN
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready upstream handshake; req_ready is high only while idle
//   req_op          00 READ, 01 WRITE, 10 ADD_SAT, 11 reserved (rejected)
//   req_addr        cell address
//   req_data        write data / addend
//   rsp_valid       one-cycle response pulse
//   rsp_data        READ: cell value, ADD_SAT: new value, WRITE/error: 0
//   rsp_err         qualifies rsp_valid: bad address/op, or a wait timeout
//   ram_en          one-cycle access strobe
//   ram_we          0 read, 1 write; meaningful while ram_en is high
//   ram_addr        held at the request address for the whole op
//   ram_din         write data; held stable while an access is outstanding
//   ram_dout        RAM read data, sampled with ram_dout_valid
//   ram_dout_valid  access-complete pulse (read data or write ack)
// -----------------------------------------------------------------------------
module cell_rmw_initiator #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 4,
    parameter int DEPTH      = 535,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_dout_valid
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // One counter serves both the post-completion gap and the wait timeout;
    // the two never run at the same time. It is sized for the larger limit.
    localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
    localparam int CNT_MAX  = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_LAST);
`ifdef RMW_TIMEOUT_EN
    localparam int TO_LAST = (TIMEOUT > 1) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_END = CNT_W'(TO_LAST);
`endif

    // Address bound compared one bit wider so a DEPTH of 2**ADDR_W still works.
    localparam int AW1 = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_X = AW1'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_MOD,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_GAP,
        S_RESP
    } state_t;

    state_t            state;
    logic [1:0]        op_q;        // registered request opcode
    logic [DATA_W-1:0] old_q;       // value read back from the cell
    logic              err_q;       // op ends with rsp_err (timeout)
    logic              gap_to_mod;  // after GAP continue to MOD, else RESP
    logic [CNT_W-1:0]  cnt;
    logic              bad_req;

    // Saturating unsigned add: any carry out of DATA_W clamps to all-ones.
    function automatic logic [DATA_W-1:0] sat_add(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    endfunction

    // Response payload for a successful op. For ADD_SAT the saturated
    // result is what was written, so it is still sitting in ram_din.
    function automatic logic [DATA_W-1:0] resp_value(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] rd_val,
        input logic [DATA_W-1:0] wr_val
    );
        case (op)
            OP_READ: return rd_val;
            OP_ADD:  return wr_val;
            default: return '0;
        endcase
    endfunction

    // ram_addr holds the registered request address for the whole op.
    assign bad_req = (op_q == OP_RSVD) || ({1'b0, ram_addr} >= DEPTH_X);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            op_q       <= '0;
            old_q      <= '0;
            err_q      <= 1'b0;
            gap_to_mod <= 1'b0;
            cnt        <= '0;
        end else begin
            // Strobes and response fields are single-cycle pulses.
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        ram_addr  <= req_addr;
                        ram_din   <= req_data;
                        err_q     <= 1'b0;
                        state     <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (bad_req) begin
                        // Rejected without touching the RAM.
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= S_RESP;
                    end else if (op_q == OP_WRITE) begin
                        ram_en <= 1'b1;
                        ram_we <= 1'b1;
                        state  <= S_WR_ISSUE;
                    end else begin
                        // READ and the read half of ADD_SAT.
                        ram_en <= 1'b1;
                        state  <= S_RD_ISSUE;
                    end
                end

                S_RD_ISSUE: begin
                    cnt   <= '0;
                    state <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (ram_dout_valid) begin
                        old_q      <= ram_dout;
                        gap_to_mod <= (op_q == OP_ADD);
                        cnt        <= '0;
                        state      <= S_GAP;
                    end
`ifdef RMW_TIMEOUT_EN
                    else if (cnt == TO_END) begin
                        err_q      <= 1'b1;
                        gap_to_mod <= 1'b0;
                        cnt        <= '0;
                        state      <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end

                S_MOD: begin
                    // ram_din still carries the addend from the request.
                    ram_din <= sat_add(old_q, ram_din);
                    ram_en  <= 1'b1;
                    ram_we  <= 1'b1;
                    state   <= S_WR_ISSUE;
                end

                S_WR_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WR_WAIT;
                end

                S_WR_WAIT: begin
                    if (ram_dout_valid) begin
                        gap_to_mod <= 1'b0;
                        cnt        <= '0;
                        state      <= S_GAP;
                    end
`ifdef RMW_TIMEOUT_EN
                    else if (cnt == TO_END) begin
                        err_q      <= 1'b1;
                        gap_to_mod <= 1'b0;
                        cnt        <= '0;
                        state      <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end

                // Idle window after every RAM completion; the RAM is busy
                // for a cycle after ram_dout_valid and must not see ram_en.
                S_GAP: begin
                    if (cnt == GAP_END) begin
                        cnt <= '0;
                        if (gap_to_mod) begin
                            state <= S_MOD;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= err_q;
                            rsp_data  <= err_q ? '0 : resp_value(op_q, old_q, ram_din);
                            state     <= S_RESP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_rmw_initiator.sv
// -----------------------------------------------------------------------------
// tb_cell_rmw_initiator
//
// Directed and randomized bench for cell_rmw_initiator. A behavioural RAM
// (3-cycle latency, one busy cycle after each completion) answers the DUT's
// port, and a separate cell-array model predicts every response from the op
// rules: READ returns the cell, WRITE stores, ADD_SAT stores min(cell+d, 15).
// -----------------------------------------------------------------------------
module tb_cell_rmw_initiator;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 4;
    localparam int DEPTH   = 535;
    localparam int GAP     = 1;
    localparam int TIMEOUT = 15;
    localparam int LAT     = 3;   // ram_dout_valid comes LAT cycles after ram_en

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout       = '0;
    logic              ram_dout_valid = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int en_cnt = 0;
    int en_cyc = 0;
    int last_vld_cyc = -100;
    int viol = 0;
    int ready_busy = 0;

    bit                mute = 0;      // RAM never completes
    bit                ram_busy = 0;
    bit                ram_nochk = 0;
    bit                ram_w = 0;
    logic [ADDR_W-1:0] ram_a = '0;
    logic [DATA_W-1:0] ram_d = '0;

    logic [DATA_W-1:0] mem  [0:1023];  // contents of the behavioural RAM
    logic [DATA_W-1:0] refm [0:1023];  // expected cell contents

    cell_rmw_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .GAP_CYCLES(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_dout_valid(ram_dout_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM, evaluated mid-cycle. Flags protocol violations:
    // ram_en while an access is outstanding or inside the post-valid busy
    // window, and ram_addr/ram_din moving while an access is outstanding.
    always @(negedge clk) begin
        ram_dout_valid = 1'b0;
        if (rst) ram_nochk = 1;
        if (ram_en === 1'b1) begin
            en_cnt++;
            en_cyc = cyc;
            if (ram_busy || (cyc - last_vld_cyc) < GAP + 1) viol++;
            if (!mute) begin
                ram_busy  = 1;
                ram_nochk = 0;
                ram_a     = ram_addr;
                ram_w     = ram_we;
                ram_d     = ram_din;
            end
        end else if (ram_busy && !ram_nochk) begin
            if (ram_addr !== ram_a || ram_din !== ram_d) viol++;
        end
        if (ram_busy && (cyc - en_cyc) == LAT) begin
            if (ram_w) mem[ram_a] = ram_d;
            else       ram_dout   = mem[ram_a];
            ram_dout_valid = 1'b1;
            last_vld_cyc   = cyc;
            ram_busy       = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output bit seen);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (req_ready === 1'b1) seen = 1;
            else tick();
        end
    endtask

    // Wait for rsp_valid; req_ready must stay low while the op is in flight.
    task automatic wait_rsp(input int limit, output bit seen);
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (rsp_valid === 1'b1) seen = 1;
            else begin
                if (req_ready !== 1'b0) ready_busy++;
                tick();
            end
        end
    endtask

    // Issue one op, predict its result from the cell model and check it.
    task automatic do_op(input logic [1:0] op, input int addr,
                         input logic [DATA_W-1:0] d, input string tag);
        logic [DATA_W-1:0] exp_d;
        logic              exp_e;
        int                exp_en;
        int                en0;
        int                sum;
        int                exp_lat;
        bit                seen;
        exp_e   = 1'b0;
        exp_d   = '0;
        exp_en  = 1;
        exp_lat = LAT + GAP + 1;
        if (op == 2'b11 || addr >= DEPTH) begin
            exp_e  = 1'b1;
            exp_en = 0;
        end else if (mute) begin
            // Only used with the timeout build: read phase times out.
            exp_e   = 1'b1;
            exp_lat = TIMEOUT + GAP + 1;
        end else begin
            case (op)
                2'b00: exp_d = refm[addr];
                2'b01: refm[addr] = d;
                default: begin
                    sum        = int'(refm[addr]) + int'(d);
                    exp_d      = (sum > 15) ? 4'hF : 4'(sum);
                    refm[addr] = exp_d;
                    exp_en     = 2;
                end
            endcase
        end

        wait_ready(seen);
        chk({tag, "_ready"}, 32'(seen), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = 10'(addr);
        req_data  = d;
        en0       = en_cnt;
        tick();
        req_valid = 1'b0;
        wait_rsp(300, seen);
        chk({tag, "_rsp_seen"}, 32'(seen), 32'd1);
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        chk({tag, "_ram_en_count"}, en_cnt - en0, exp_en);
        if (exp_en > 0 && seen) chk({tag, "_latency"}, cyc - en_cyc, exp_lat);
        tick();
        chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        bit  seen;
        int  en0;
        int  rsp_cnt;
        int  v;
        int  a;

        for (int i = 0; i < 1024; i++) begin
            mem[i]  = '0;
            refm[i] = '0;
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_data  = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        rst = 1'b0;
        tick();

        // Basic write / read back
        do_op(2'b01, 5, 4'h9, "wr5");
        do_op(2'b00, 5, 4'h0, "rd5");

        // Saturating add
        do_op(2'b01, 7, 4'hC, "wr7");
        do_op(2'b10, 7, 4'h3, "add7_to_f");
        do_op(2'b10, 7, 4'h2, "add7_sat");
        do_op(2'b00, 7, 4'h0, "rd7");

        // Rejections and address boundary
        do_op(2'b00, 535, 4'h0, "rd_oob");
        do_op(2'b11, 1, 4'h5, "op_rsvd");
        do_op(2'b01, 534, 4'h6, "wr_last");
        do_op(2'b00, 534, 4'h0, "rd_last");

        // Back-to-back: req_valid held, second op carries a new address
        wait_ready(seen);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 10'd5;
        req_data  = '0;
        tick();
        req_addr = 10'd7;
        wait_rsp(100, seen);
        chk("b2b_rsp1_seen", 32'(seen), 32'd1);
        chk("b2b_rsp1_data", 32'(rsp_data), 32'(refm[5]));
        chk("b2b_ready_in_rsp", 32'(req_ready), 32'd0);
        tick();
        chk("b2b_ready_after_rsp", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("b2b_second_accepted", 32'(req_ready), 32'd0);
        wait_rsp(100, seen);
        chk("b2b_rsp2_seen", 32'(seen), 32'd1);
        chk("b2b_rsp2_data", 32'(rsp_data), 32'(refm[7]));
        tick();

        // Reset while the read half of an ADD_SAT is outstanding
        wait_ready(seen);
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_addr  = 10'd5;
        req_data  = 4'h3;
        en0       = en_cnt;
        tick();
        req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (en_cnt != en0) seen = 1;
            else tick();
        end
        chk("mid_rst_ram_en_seen", 32'(seen), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ram_en", 32'(ram_en), 32'd0);
        rst = 1'b0;
        en0     = en_cnt;
        rsp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid === 1'b1) rsp_cnt++;
            tick();
        end
        chk("mid_rst_no_rsp", rsp_cnt, 0);
        chk("mid_rst_no_ram_en", en_cnt - en0, 0);
        chk("mid_rst_cell_kept", 32'(mem[5]), 32'(refm[5]));
        do_op(2'b00, 5, 4'h0, "rd5_after_rst");

        // Randomized mix against the cell model
        for (int n = 0; n < 40; n++) begin
            v = $urandom_range(0, 9);
            a = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 15) : $urandom_range(530, 540);
            if (v < 3)      do_op(2'b00, a, 4'(0), "rnd_rd");
            else if (v < 6) do_op(2'b01, a, 4'($urandom_range(0, 15)), "rnd_wr");
            else if (v < 9) do_op(2'b10, a, 4'($urandom_range(0, 15)), "rnd_add");
            else            do_op(2'b11, a, 4'($urandom_range(0, 15)), "rnd_rsvd");
        end

`ifdef RMW_TIMEOUT_EN
        // RAM never answers: each op ends in an error response
        mute = 1;
        do_op(2'b00, 3, 4'h0, "to_read");
        do_op(2'b10, 4, 4'h5, "to_add");
        mute = 0;
        repeat (3) tick();
`else
        // RAM never answers: the initiator keeps waiting until reset
        mute = 1;
        wait_ready(seen);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 10'd2;
        req_data  = '0;
        tick();
        req_valid = 1'b0;
        wait_rsp(40, seen);
        chk("hang_no_rsp", 32'(seen), 32'd0);
        chk("hang_ready_low", 32'(req_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        mute = 0;
        chk("hang_rst_ready", 32'(req_ready), 32'd1);
        repeat (3) tick();
`endif
        do_op(2'b00, 7, 4'h0, "rd7_final");

        // Final RAM image and protocol bookkeeping
        chk("ram_protocol_viol", viol, 0);
        chk("ready_while_busy", ready_busy, 0);
        for (int i = 0; i < 16; i++) chk("ram_cell", 32'(mem[i]), 32'(refm[i]));
        for (int i = 530; i < 541; i++) chk("ram_cell_hi", 32'(mem[i]), 32'(refm[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
